// File: rtl/drum_mixer_pkg.sv
// Shared types and defaults for the drum_mixer one-shot sample player.
package drum_mixer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPlay
  } voice_state_t;

  localparam int unsigned DefNch       = 4;
  localparam int unsigned DefSampleW   = 8;
  localparam int unsigned DefAddrW     = 12;
  localparam int unsigned DefSampleLen = 4000;
  localparam int unsigned DefClkDiv    = 250;

  // Extra sum bits so that NCH full-scale samples cannot wrap before saturation.
  function automatic int unsigned mix_guard_w(int unsigned nch);
    return $clog2(nch);
  endfunction

endpackage

// File: rtl/drum_mixer_if.sv
// Trigger/ROM/audio bundle of drum_mixer; the vol field exists only with DRUM_MIXER_VOLUME_EN.
interface drum_mixer_if
  import drum_mixer_pkg::*;
#(
  parameter int unsigned NCH      = DefNch,
  parameter int unsigned SAMPLE_W = DefSampleW,
  parameter int unsigned ADDR_W   = DefAddrW
);

  logic [NCH-1:0]          trig;
  logic [NCH*ADDR_W-1:0]   rom_addr;
  logic [NCH*SAMPLE_W-1:0] rom_data;
`ifdef DRUM_MIXER_VOLUME_EN
  logic [2*NCH-1:0]        vol;
`endif
  logic [NCH-1:0]          active;
  logic [SAMPLE_W-1:0]     mix;
  logic                    mix_valid;
  logic                    clip;
  logic                    pwm_out;

`ifdef DRUM_MIXER_VOLUME_EN
  modport master (
    output trig, rom_data, vol,
    input  rom_addr, active, mix, mix_valid, clip, pwm_out
  );
  modport slave (
    input  trig, rom_data, vol,
    output rom_addr, active, mix, mix_valid, clip, pwm_out
  );
`else
  modport master (
    output trig, rom_data,
    input  rom_addr, active, mix, mix_valid, clip, pwm_out
  );
  modport slave (
    input  trig, rom_data,
    output rom_addr, active, mix, mix_valid, clip, pwm_out
  );
`endif

endinterface

// File: rtl/drum_voice.sv
// One voice of drum_mixer: trigger-driven IDLE/LOAD/PLAY FSM and sample address counter.
module drum_voice
  import drum_mixer_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned SAMPLE_LEN = DefSampleLen
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_edge,
  input  logic              tick,
  output logic [ADDR_W-1:0] addr,
  output logic              playing,
  output logic              active
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(SAMPLE_LEN - 1);

  voice_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // A trigger edge restarts the voice from any state and takes priority over a tick.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (trig_edge) begin
      state_d = StLoad;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StLoad: state_d = StPlay;
        StPlay: begin
          if (tick) begin
            if (addr_q == LastAddr) begin
              state_d = StIdle;
              addr_d  = '0;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = StIdle;
          addr_d  = '0;
        end
      endcase
    end
  end

  assign addr    = addr_q;
  assign playing = (state_q == StPlay);
  assign active  = (state_q != StIdle);

endmodule

// File: rtl/drum_mixer.sv
// N-voice one-shot sample player with saturating mixer and PWM DAC output.
// Define DRUM_MIXER_VOLUME_EN to enable per-voice right-shift attenuation via bus.vol.
module drum_mixer
  import drum_mixer_pkg::*;
#(
  parameter int unsigned NCH        = DefNch,
  parameter int unsigned SAMPLE_W   = DefSampleW,
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned SAMPLE_LEN = DefSampleLen,
  parameter int unsigned CLK_DIV    = DefClkDiv
) (
  input logic         clk,
  input logic         rst,
  drum_mixer_if.slave bus
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned SumW = SAMPLE_W + mix_guard_w(NCH);
  localparam logic [SumW-1:0] MixMax = SumW'({SAMPLE_W{1'b1}});

  logic [DivW-1:0]                div_q;
  logic                           tick;
  logic [NCH-1:0]                 trig_q;
  logic [NCH-1:0]                 trig_edge;
  logic [NCH-1:0]                 playing;
  logic [NCH-1:0]                 active;
  logic [NCH-1:0][ADDR_W-1:0]     voice_addr;
  logic [SumW-1:0]                sum;
  logic [SAMPLE_W-1:0]            term;
  logic [SAMPLE_W-1:0]            mix_q;
  logic                           mix_valid_q;
  logic                           clip_q;
  logic [SAMPLE_W-1:0]            pwm_cnt_q;
  logic                           pwm_q;

  assign tick = (div_q == DivW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // All-ones reset keeps a trigger held through reset from firing.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q <= '1;
    end else begin
      trig_q <= bus.trig;
    end
  end

  assign trig_edge = bus.trig & ~trig_q;

  for (genvar i = 0; i < NCH; i++) begin : g_voice
    drum_voice #(
      .ADDR_W     (ADDR_W),
      .SAMPLE_LEN (SAMPLE_LEN)
    ) u_voice (
      .clk       (clk),
      .rst       (rst),
      .trig_edge (trig_edge[i]),
      .tick      (tick),
      .addr      (voice_addr[i]),
      .playing   (playing[i]),
      .active    (active[i])
    );
  end

  assign bus.rom_addr = voice_addr;
  assign bus.active   = active;

  // A voice being retriggered this cycle is already heading to LOAD, so it adds nothing.
  always_comb begin
    sum  = '0;
    term = '0;
    for (int i = 0; i < NCH; i++) begin
      term = bus.rom_data[i*SAMPLE_W +: SAMPLE_W];
`ifdef DRUM_MIXER_VOLUME_EN
      term = term >> bus.vol[2*i +: 2];
`endif
      if (playing[i] && !trig_edge[i]) begin
        sum = sum + SumW'(term);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
    end else if (tick) begin
      mix_q       <= (sum > MixMax) ? {SAMPLE_W{1'b1}} : sum[SAMPLE_W-1:0];
      mix_valid_q <= 1'b1;
      clip_q      <= (sum > MixMax);
    end else begin
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      pwm_q     <= (pwm_cnt_q < mix_q);
    end
  end

  assign bus.mix       = mix_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.clip      = clip_q;
  assign bus.pwm_out   = pwm_q;

endmodule

// File: tb/tb_drum_mixer.sv
// Directed self-checking bench for drum_mixer with a small synchronous ROM model.
module tb_drum_mixer;
  import drum_mixer_pkg::*;

  localparam int unsigned NCH        = 4;
  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned SAMPLE_LEN = 16;
  localparam int unsigned CLK_DIV    = 8;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  logic [SAMPLE_W-1:0] rom [NCH][SAMPLE_LEN];

  bit watch0   = 1'b0;
  bit dropped0 = 1'b0;
  bit pwm_win  = 1'b0;
  int pwm_cyc  = 0;
  int pwm_hi   = 0;

  drum_mixer_if #(
    .NCH      (NCH),
    .SAMPLE_W (SAMPLE_W),
    .ADDR_W   (ADDR_W)
  ) bus ();

  drum_mixer #(
    .NCH        (NCH),
    .SAMPLE_W   (SAMPLE_W),
    .ADDR_W     (ADDR_W),
    .SAMPLE_LEN (SAMPLE_LEN),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      bus.rom_data[i*SAMPLE_W +: SAMPLE_W] <= rom[i][bus.rom_addr[i*ADDR_W +: ADDR_W]];
    end
  end

  always @(negedge clk) begin
    if (watch0 && !bus.active[0]) dropped0 = 1'b1;
    if (pwm_win && pwm_cyc < 256) begin
      pwm_cyc++;
      if (bus.pwm_out) pwm_hi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic rom_default();
    for (int i = 0; i < NCH; i++)
      for (int a = 0; a < SAMPLE_LEN; a++) rom[i][a] = SAMPLE_W'(16 * i + a + 1);
  endtask

  // Returns at the negedge where mix_valid is high (cycle after a tick).
  task automatic next_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mix_valid && n < 4 * CLK_DIV);
    check("mix_valid_seen", 32'(bus.mix_valid), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.active != '0; i++) next_valid();
    check("voices_idle", 32'(bus.active), 32'd0);
  endtask

  initial begin
    int s;
    rst      = 1'b1;
    bus.trig = 4'hF;
    bus.rom_data = '0;
`ifdef DRUM_MIXER_VOLUME_EN
    bus.vol = '0;
`endif
    rom_default();

    // 1: reset with triggers held high
    repeat (4) @(negedge clk);
    check("rst_active", 32'(bus.active), 32'd0);
    check("rst_mix", 32'(bus.mix), 32'd0);
    check("rst_mix_valid", 32'(bus.mix_valid), 32'd0);
    check("rst_clip", 32'(bus.clip), 32'd0);
    check("rst_pwm", 32'(bus.pwm_out), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_valid();
      check("held_trig_active", 32'(bus.active), 32'd0);
      check("held_trig_mix", 32'(bus.mix), 32'd0);
    end

    // 2: single voice plays its whole sample
    bus.trig = 4'h0;
    next_valid();
    bus.trig = 4'b0010;
    @(negedge clk);
    check("v1_active", 32'(bus.active), 32'b0010);
    for (int k = 1; k <= 16; k++) begin
      next_valid();
      check("v1_mix", 32'(bus.mix), 32'(16 + k));
    end
    check("v1_done_active", 32'(bus.active), 32'd0);
    next_valid();
    check("v1_after_mix", 32'(bus.mix), 32'd0);

    // 3: retrigger voice 0 at addr 9
    bus.trig = 4'h0;
    next_valid();
    bus.trig = 4'b0001;
    @(negedge clk);
    check("v0_active", 32'(bus.active), 32'b0001);
    watch0 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      next_valid();
      check("v0_mix", 32'(bus.mix), 32'(k));
      bus.trig = 4'b0000;
    end
    check("v0_addr9", 32'(bus.rom_addr[ADDR_W-1:0]), 32'd9);
    bus.trig = 4'b0001;
    @(negedge clk);
    check("v0_retrig_addr", 32'(bus.rom_addr[ADDR_W-1:0]), 32'd0);
    next_valid();
    check("v0_restart_mix", 32'(bus.mix), 32'd1);
    watch0 = 1'b0;
    check("v0_never_dropped", 32'(dropped0), 32'd0);
    wait_idle();

    // 4: all voices, then saturation with ROM[3]=200
    bus.trig = 4'h0;
    next_valid();
    bus.trig = 4'hF;
    for (int k = 1; k <= 16; k++) begin
      next_valid();
      check("all_mix", 32'(bus.mix), 32'(4 * k + 96));
      check("all_clip", 32'(bus.clip), 32'd0);
    end
    wait_idle();
    bus.trig = 4'h0;
    for (int a = 0; a < SAMPLE_LEN; a++) rom[3][a] = 8'd200;
    next_valid();
    bus.trig = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      next_valid();
      s = 3 * k + 248;
      check("sat_mix", 32'(bus.mix), (s > 255) ? 32'd255 : 32'(s));
      check("sat_clip", 32'(bus.clip), (s > 255) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("clip_pulse_end", 32'(bus.clip), 32'd0);
    check("valid_pulse_end", 32'(bus.mix_valid), 32'd0);
    wait_idle();
    bus.trig = 4'h0;
    rom_default();

    // 5: edge coincident with tick
    next_valid();
    repeat (CLK_DIV - 1) @(negedge clk);
    bus.trig = 4'b0100;
    next_valid();
    check("edge_tick_mix", 32'(bus.mix), 32'd0);
    check("edge_tick_active", 32'(bus.active), 32'b0100);
    next_valid();
    check("edge_tick_first", 32'(bus.mix), 32'd33);
    wait_idle();
    bus.trig = 4'h0;

    // 6: PWM at mix=64 held by staggered voices, then mix=0
    for (int a = 0; a < SAMPLE_LEN; a++) begin
      rom[0][a] = 8'd64;
      for (int i = 1; i < NCH; i++) rom[i][a] = (a < 8) ? 8'd0 : 8'd64;
    end
    next_valid();
    bus.trig = 4'b0001;
    for (int v = 1; v <= 40; v++) begin
      next_valid();
      check("pwm_mix64", 32'(bus.mix), 32'd64);
      if (v == 2) pwm_win = 1'b1;
      if (v == 8) bus.trig = 4'b0011;
      if (v == 16) bus.trig = 4'b0111;
      if (v == 24) bus.trig = 4'b1111;
    end
    check("pwm64_cycles", 32'(pwm_cyc), 32'd256);
    check("pwm64_high", 32'(pwm_hi), 32'd64);
    pwm_win = 1'b0;
    check("pwm_done_active", 32'(bus.active), 32'd0);
    bus.trig = 4'h0;
    next_valid();
    check("pwm_mix0", 32'(bus.mix), 32'd0);
    @(negedge clk);
    pwm_cyc = 0;
    pwm_hi  = 0;
    pwm_win = 1'b1;
    repeat (260) @(negedge clk);
    pwm_win = 1'b0;
    check("pwm0_cycles", 32'(pwm_cyc), 32'd256);
    check("pwm0_high", 32'(pwm_hi), 32'd0);
    rom_default();

`ifdef DRUM_MIXER_VOLUME_EN
    bus.vol = 8'h02;
    next_valid();
    bus.trig = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      next_valid();
      check("vol_mix", 32'(bus.mix), 32'(k >> 2));
    end
    wait_idle();
    bus.trig = 4'h0;
    bus.vol  = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
